// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: op codes, access sizes, lane-select constants and FSM states
package mem_req_ctrl_pkg;
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [3:0] SEL_BYTE0 = 4'b1000;
    localparam logic [3:0] SEL_HALF0 = 4'b1100;
    localparam logic [3:0] SEL_HALF1 = 4'b0011;
    localparam logic [3:0] SEL_WORD  = 4'b1111;
    localparam int DEFAULT_READ_LATENCY = 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_req_ctrl_lane.sv
// mem_lane_align: big-endian lane select, store replication, load extension
// and op legality / alignment decode, purely combinational.
module mem_lane_align
    import mem_req_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_placed,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);
    logic [1:0]  size;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    assign size = op[1:0];
    assign illegal = !(op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW});
    assign misaligned = !illegal && ((size == SZ_HALF && addr[0]) || (size != SZ_BYTE && size != SZ_HALF && addr != 2'b00));
    assign sel = size == SZ_BYTE ? SEL_BYTE0 >> addr : size == SZ_HALF ? (addr[1] ? SEL_HALF1 : SEL_HALF0) : SEL_WORD;
    assign wdata_placed = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    // Byte offset 0 lives in the top byte, so shift right by (3-k)*8.
    assign byte_lane = 8'(rdata >> {~addr, 3'b000});
    assign half_lane = addr[1] ? rdata[15:0] : rdata[31:16];
    assign sext = !op[2];
    assign rdata_ext = size == SZ_BYTE ? {{24{sext & byte_lane[7]}}, byte_lane}
                     : size == SZ_HALF ? {{16{sext & half_lane[15]}}, half_lane} : rdata;
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage load/store to data-memory port initiator with
// request capture, configurable read latency and one-cycle response pulse.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              resp_illegal,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    state_t state, next;
    logic [3:0]        op_q, cnt, sel_q, al_sel;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, al_wdata, al_rdata;
    logic              al_mis, al_ill, idle, access, accept;

    assign idle = state == IDLE;
    assign access = state == ACCESS;
    assign accept = idle && req_valid;

    // Decode the live request while idle, the captured one afterwards.
    mem_lane_align u_align (
        .op(idle ? req_op : op_q),
        .addr(idle ? req_addr[1:0] : addr_q[1:0]),
        .wdata(req_wdata),
        .rdata(mem_rdata),
        .sel(al_sel),
        .wdata_placed(al_wdata),
        .rdata_ext(al_rdata),
        .misaligned(al_mis),
        .illegal(al_ill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0;
            addr_q <= '0;
            sel_q <= '0;
            wdata_q <= '0;
            cnt <= '0;
            resp_rdata <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                op_q <= req_op;
                addr_q <= req_addr;
                sel_q <= al_sel;
                wdata_q <= al_wdata;
                cnt <= 4'(READ_LATENCY - 1);
                resp_misaligned <= al_mis;
                resp_illegal <= al_ill;
            end
            if (access && !op_q[3]) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else resp_rdata <= al_rdata;
            end
            if (state == RESP) begin
                resp_rdata <= '0;
                resp_misaligned <= 1'b0;
                resp_illegal <= 1'b0;
            end
        end
    end

    always_comb begin
        next = state;
        next = idle ? (req_valid ? ((al_ill || al_mis) ? RESP : ACCESS) : IDLE)
             : access ? ((op_q[3] || cnt == 4'd0) ? RESP : ACCESS) : IDLE;
        req_ready = idle;
        resp_valid = state == RESP;
        mem_ce = access;
        mem_we = access && op_q[3];
        mem_addr = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_sel = access ? sel_q : '0;
        mem_wdata = access ? wdata_q : '0;
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench for mem_req_ctrl at read latency 1 and 3.
module tb_mem_req_ctrl;
    typedef struct {logic [31:0] rdata; logic mis; logic ill;} exp_t;
    exp_t sbq[$];
    logic clk = 0, rst = 0, rv1 = 0, rv3 = 0, sel3 = 0;
    logic [3:0] req_op = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic rdy1, vld1, mis1, ill1, ce1, we1, rdy3, vld3, mis3, ill3, ce3, we3;
    logic [31:0] rd1, addr1, wd1, rd3, addr3, wd3;
    logic [3:0] ms1, ms3;
    logic rdy, vld, mis, ill, ce, we;
    logic [31:0] rd, maddr, mwd;
    logic [3:0] msel;
    int total = 0, bad = 0;
    int obs_lat, obs_ce, obs_we;
    logic obs_ready, obs_stable;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0] obs_sel;
    logic [33:0] obs_resp;

    always #5 clk = ~clk;

    mem_req_ctrl #(.READ_LATENCY(1), .ADDR_W(32)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(vld1), .resp_rdata(rd1), .resp_misaligned(mis1), .resp_illegal(ill1),
        .mem_ce(ce1), .mem_we(we1), .mem_addr(addr1), .mem_sel(ms1), .mem_wdata(wd1), .mem_rdata(mem_rdata));
    mem_req_ctrl #(.READ_LATENCY(3), .ADDR_W(32)) u3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(vld3), .resp_rdata(rd3), .resp_misaligned(mis3), .resp_illegal(ill3),
        .mem_ce(ce3), .mem_we(we3), .mem_addr(addr3), .mem_sel(ms3), .mem_wdata(wd3), .mem_rdata(mem_rdata));

    assign rdy = sel3 ? rdy3 : rdy1;
    assign vld = sel3 ? vld3 : vld1;
    assign mis = sel3 ? mis3 : mis1;
    assign ill = sel3 ? ill3 : ill1;
    assign ce = sel3 ? ce3 : ce1;
    assign we = sel3 ? we3 : we1;
    assign rd = sel3 ? rd3 : rd1;
    assign maddr = sel3 ? addr3 : addr1;
    assign mwd = sel3 ? wd3 : wd1;
    assign msel = sel3 ? ms3 : ms1;

    // Drives one request, pushes its expected response, then watches the
    // memory port every cycle until the response pulse or a 40-cycle budget.
    task automatic run_req(input logic l3, input logic [3:0] op, input logic [31:0] addr, wdata, rd_val,
                           input logic [31:0] exp_rd, input logic emis, input logic eill);
        exp_t e;
        e.rdata = exp_rd; e.mis = emis; e.ill = eill;
        sbq.push_back(e);
        @(negedge clk);
        sel3 = l3; obs_ready = rdy;
        req_op = op; req_addr = addr; req_wdata = wdata; mem_rdata = rd_val;
        if (l3) rv3 = 1; else rv1 = 1;
        @(posedge clk);
        obs_lat = 0; obs_ce = 0; obs_we = 0; obs_stable = 1; obs_resp = 'x;
        obs_addr = 0; obs_sel = 0; obs_wdata = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            rv1 = 0; rv3 = 0;
            if (vld) begin obs_lat = i; obs_resp = {rd, mis, ill}; break; end
            if (ce) begin
                if (obs_ce == 0) begin obs_addr = maddr; obs_sel = msel; obs_wdata = mwd; end
                else if (maddr !== obs_addr || msel !== obs_sel) obs_stable = 0;
                mem_rdata = rd_val + 32'(obs_ce);
                obs_ce++;
            end
            if (we) obs_we++;
            @(posedge clk);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL %s: scoreboard empty", name); return; end
        e = sbq.pop_front();
        if (obs_resp !== {e.rdata, e.mis, e.ill}) begin bad++; $display("FAIL %s resp: got=%h want=%h", name, obs_resp, {e.rdata, e.mis, e.ill}); end
    endtask

    task automatic test_reset();
        rst = 1;
        #3;
        total++; if ({vld1, rd1, mis1, ill1, ce1, we1, addr1, ms1, wd1} !== '0 || rdy1 !== 1) begin bad++; $display("FAIL reset_u1: got=%h ready=%b want=0 ready=1", {vld1, rd1, mis1, ill1, ce1, we1, addr1, ms1, wd1}, rdy1); end
        total++; if ({vld3, rd3, mis3, ill3, ce3, we3, addr3, ms3, wd3} !== '0 || rdy3 !== 1) begin bad++; $display("FAIL reset_u3: got=%h ready=%b want=0 ready=1", {vld3, rd3, mis3, ill3, ce3, we3, addr3, ms3, wd3}, rdy3); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
    endtask

    task automatic test_store();
        run_req(0, 4'b1010, 32'h104, 32'h41, 32'h0, 32'h0, 0, 0);
        total++; if (obs_lat !== 2) begin bad++; $display("FAIL sw_lat: got=%0d want=2", obs_lat); end
        total++; if ({obs_ce, obs_we} !== {32'd1, 32'd1}) begin bad++; $display("FAIL sw_ce_we: got=%0d/%0d want=1/1", obs_ce, obs_we); end
        total++; if ({obs_addr, obs_sel, obs_wdata} !== {32'h104, 4'b1111, 32'h41}) begin bad++; $display("FAIL sw_port: got=%h %b %h want=104 1111 41", obs_addr, obs_sel, obs_wdata); end
        pop_check("sw");
        run_req(0, 4'b1000, 32'h105, 32'hAB, 32'h0, 32'h0, 0, 0);
        total++; if ({obs_sel, obs_wdata, obs_addr} !== {4'b0100, 32'hABABABAB, 32'h104}) begin bad++; $display("FAIL sb_port: got=%b %h %h want=0100 abababab 104", obs_sel, obs_wdata, obs_addr); end
        total++; if (obs_we !== 1) begin bad++; $display("FAIL sb_we: got=%0d want=1", obs_we); end
        pop_check("sb");
        run_req(0, 4'b1001, 32'h106, 32'h5A5A1234, 32'h0, 32'h0, 0, 0);
        total++; if ({obs_sel, obs_wdata} !== {4'b0011, 32'h12341234}) begin bad++; $display("FAIL sh_port: got=%b %h want=0011 12341234", obs_sel, obs_wdata); end
        pop_check("sh");
    endtask

    task automatic test_load_byte();
        run_req(0, 4'b0000, 32'h103, 32'h0, 32'h123456F0, 32'hFFFFFFF0, 0, 0);
        total++; if ({obs_sel, obs_we, obs_lat} !== {4'b0001, 32'd0, 32'd2}) begin bad++; $display("FAIL lb_port: got=%b we=%0d lat=%0d want=0001 0 2", obs_sel, obs_we, obs_lat); end
        pop_check("lb");
        run_req(0, 4'b0100, 32'h103, 32'h0, 32'h123456F0, 32'h000000F0, 0, 0);
        total++; if (obs_we !== 0) begin bad++; $display("FAIL lbu_we: got=%0d want=0", obs_we); end
        pop_check("lbu");
        run_req(0, 4'b0000, 32'h100, 32'h0, 32'h923456F0, 32'hFFFFFF92, 0, 0);
        pop_check("lb_off0");
    endtask

    task automatic test_load_half();
        run_req(0, 4'b0001, 32'h102, 32'h0, 32'h12348001, 32'hFFFF8001, 0, 0);
        total++; if ({obs_sel, obs_addr} !== {4'b0011, 32'h100}) begin bad++; $display("FAIL lh_port: got=%b %h want=0011 100", obs_sel, obs_addr); end
        pop_check("lh");
        run_req(0, 4'b0101, 32'h102, 32'h0, 32'h12348001, 32'h00008001, 0, 0);
        pop_check("lhu");
        run_req(0, 4'b0001, 32'h100, 32'h0, 32'h12348001, 32'h00001234, 0, 0);
        total++; if (obs_sel !== 4'b1100) begin bad++; $display("FAIL lh0_sel: got=%b want=1100", obs_sel); end
        pop_check("lh0");
        run_req(0, 4'b0010, 32'h108, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        pop_check("lw");
    endtask

    task automatic test_errors();
        run_req(0, 4'b0010, 32'h102, 32'h0, 32'h11111111, 32'h0, 1, 0);
        total++; if ({obs_lat, obs_ce} !== {32'd1, 32'd0}) begin bad++; $display("FAIL lw_mis_timing: got lat=%0d ce=%0d want=1 0", obs_lat, obs_ce); end
        pop_check("lw_mis");
        run_req(0, 4'b1001, 32'h101, 32'h0, 32'h0, 32'h0, 1, 0);
        total++; if (obs_ce !== 0) begin bad++; $display("FAIL sh_mis_ce: got=%0d want=0", obs_ce); end
        pop_check("sh_mis");
        run_req(0, 4'b1111, 32'h100, 32'h0, 32'h0, 32'h0, 0, 1);
        total++; if ({obs_lat, obs_ce} !== {32'd1, 32'd0}) begin bad++; $display("FAIL ill_timing: got lat=%0d ce=%0d want=1 0", obs_lat, obs_ce); end
        pop_check("ill_1111");
        run_req(0, 4'b0011, 32'h101, 32'h0, 32'h0, 32'h0, 0, 1);
        pop_check("ill_0011");
    endtask

    task automatic test_back_to_back();
        run_req(0, 4'b1010, 32'h10, 32'h1, 32'h0, 32'h0, 0, 0);
        pop_check("b2b_a");
        @(negedge clk);
        total++; if ({vld1, rdy1} !== 2'b01) begin bad++; $display("FAIL b2b_pulse: got valid=%b ready=%b want=0 1", vld1, rdy1); end
        run_req(0, 4'b0010, 32'h14, 32'h0, 32'h77, 32'h77, 0, 0);
        total++; if (obs_ready !== 1) begin bad++; $display("FAIL b2b_ready: got=%b want=1", obs_ready); end
        pop_check("b2b_b");
    endtask

    task automatic test_latency3();
        logic seen;
        run_req(1, 4'b0010, 32'h200, 32'h0, 32'hCAFE0000, 32'hCAFE0002, 0, 0);
        total++; if ({obs_lat, obs_ce, obs_we} !== {32'd4, 32'd3, 32'd0}) begin bad++; $display("FAIL l3_timing: got lat=%0d ce=%0d we=%0d want=4 3 0", obs_lat, obs_ce, obs_we); end
        total++; if ({obs_stable, obs_addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL l3_addr: got stable=%b addr=%h want=1 200", obs_stable, obs_addr); end
        pop_check("l3_lw");
        run_req(1, 4'b1010, 32'h204, 32'h9, 32'h0, 32'h0, 0, 0);
        total++; if (obs_lat !== 2) begin bad++; $display("FAIL l3_sw_lat: got=%0d want=2", obs_lat); end
        pop_check("l3_sw");
        @(negedge clk);
        req_op = 4'b0010; req_addr = 32'h200; rv3 = 1;
        @(posedge clk);
        @(negedge clk); rv3 = 0;
        @(posedge clk);
        #2 rst = 1;
        #1;
        total++; if ({vld3, rd3, mis3, ill3, ce3, we3, addr3, ms3, wd3} !== '0 || rdy3 !== 1) begin bad++; $display("FAIL abort_load: got=%h ready=%b want=0 ready=1", {vld3, ce3, addr3, ms3}, rdy3); end
        @(negedge clk); rst = 0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (vld3) seen = 1; end
        total++; if ({seen, rdy3} !== 2'b01) begin bad++; $display("FAIL abort_noresp: got seen=%b ready=%b want=0 1", seen, rdy3); end
        req_op = 4'b1010; req_addr = 32'h208; req_wdata = 32'h5; rv3 = 1;
        @(posedge clk);
        #2;
        total++; if (we3 !== 1) begin bad++; $display("FAIL abort_st_pre: got we=%b want=1", we3); end
        rst = 1;
        #1;
        total++; if ({we3, ce3} !== 2'b00) begin bad++; $display("FAIL abort_st_we: got we=%b ce=%b want=0 0", we3, ce3); end
        @(negedge clk); rst = 0; rv3 = 0;
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_byte();
        test_load_half();
        test_errors();
        test_back_to_back();
        test_latency3();
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover: got=%0d want=0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
